// File: rtl/ula_entrada_operandos.sv
// Operand-entry sequencer for the ULA: debounced push-button steps through A, B and
// operation loads, waits for the ULA pipeline, then captures and holds its result.
module ula_entrada_operandos #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned ULA_LATENCY     = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [5:0] dado,
  input  logic [2:0] op_sel,
  input  logic       modo_sel,
  input  logic       botao,
  input  logic [5:0] ula_resultado,
  input  logic       ula_overflow,
  input  logic       ula_zero,
  output logic [5:0] A,
  output logic [5:0] B,
  output logic [2:0] operacao,
  output logic       modo,
  output logic       valido,
  output logic [5:0] resultado,
  output logic       overflow,
  output logic       zero,
  output logic       pronto,
  output logic [2:0] estado
);

  localparam int unsigned DATA_W  = 6;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned DEB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned WAIT_W  = (ULA_LATENCY > 1) ? $clog2(ULA_LATENCY + 1) : 1;
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(ULA_LATENCY);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(1);

  typedef enum logic [2:0] {
    ESPERA_A  = 3'd0,
    ESPERA_B  = 3'd1,
    ESPERA_OP = 3'd2,
    CALCULA   = 3'd3,
    EXIBE     = 3'd4
  } state_t;

  // Button synchronizer and debouncer; press is a one-cycle pulse on a stable fall.
  logic             sync_0;
  logic             sync_1;
  logic             stable;
  logic [DEB_W-1:0] deb_cnt;
  logic             press;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_0  <= 1'b1;
      sync_1  <= 1'b1;
      stable  <= 1'b1;
      deb_cnt <= '0;
      press   <= 1'b0;
    end else begin
      sync_0 <= botao;
      sync_1 <= sync_0;
      press  <= 1'b0;
      if (sync_1 == stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        stable  <= sync_1;
        deb_cnt <= '0;
        press   <= ~sync_1;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // Sequencer state and datapath registers.
  state_t              state_q;
  state_t              state_d;
  logic [WAIT_W-1:0]   wait_q;
  logic [WAIT_W-1:0]   wait_d;
  logic [DATA_W-1:0]   a_d;
  logic [DATA_W-1:0]   b_d;
  logic [OP_W-1:0]     op_d;
  logic                modo_d;
  logic                valido_d;
  logic [DATA_W-1:0]   res_d;
  logic                ovf_d;
  logic                zero_d;
  logic                pronto_d;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ESPERA_A;
      wait_q    <= '0;
      A         <= '0;
      B         <= '0;
      operacao  <= '0;
      modo      <= 1'b0;
      valido    <= 1'b0;
      resultado <= '0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      pronto    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      A         <= a_d;
      B         <= b_d;
      operacao  <= op_d;
      modo      <= modo_d;
      valido    <= valido_d;
      resultado <= res_d;
      overflow  <= ovf_d;
      zero      <= zero_d;
      pronto    <= pronto_d;
    end
  end

  // Next-state and register loads; switches are only sampled on the press cycle.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    a_d      = A;
    b_d      = B;
    op_d     = operacao;
    modo_d   = modo;
    valido_d = valido;
    res_d    = resultado;
    ovf_d    = overflow;
    zero_d   = zero;
    pronto_d = pronto;
    case (state_q)
      ESPERA_A: begin
        if (press) begin
          a_d     = dado;
          state_d = ESPERA_B;
        end
      end
      ESPERA_B: begin
        if (press) begin
          b_d     = dado;
          state_d = ESPERA_OP;
        end
      end
      ESPERA_OP: begin
        if (press) begin
          op_d     = op_sel;
          modo_d   = modo_sel;
          valido_d = 1'b1;
          wait_d   = WAIT_INIT;
          state_d  = CALCULA;
        end
      end
      CALCULA: begin
        // Presses here are deliberately dropped, including one on the capture edge.
        if (wait_q == WAIT_LAST) begin
          res_d    = ula_resultado;
          ovf_d    = ula_overflow;
          zero_d   = ula_zero;
          pronto_d = 1'b1;
          state_d  = EXIBE;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      EXIBE: begin
        if (press) begin
          valido_d = 1'b0;
          pronto_d = 1'b0;
          state_d  = ESPERA_A;
        end
      end
      default: begin
        state_d = ESPERA_A;
      end
    endcase
  end

  assign estado = state_q;

endmodule

// File: doc/ula_entrada_operandos.md
# ula_entrada_operandos

Operand-entry sequencer that sits directly upstream of the ULA on the DE2 board. A single push-button, debounced in this block, steps through three loads from the switches: operand A, then operand B, then operation and mode. The block then drives the ULA with stable operands and waits a fixed number of cycles for the ULA's registered pipeline. It captures the ULA result, overflow and zero flags and holds them for display until the next button press.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000: cycles a new button level must be stable before it is accepted (10 ms at 50 MHz); minimum 2.
- ULA_LATENCY, 3: cycles from operand/operation load to valid ULA result; minimum 1.

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dado  in  6  switch data for A or B.
- op_sel  in  3  switch operation code.
- modo_sel  in  1  switch mode: 1 = logic, 0 = arithmetic.
- botao  in  1  raw push-button, active-low (pressed = 0), asynchronous to CLOCK_50.
- ula_resultado  in  6  ULA result.
- ula_overflow  in  1  ULA overflow flag.
- ula_zero  in  1  ULA zero flag.
- A  out  6  operand A to the ULA.
- B  out  6  operand B to the ULA.
- operacao  out  3  operation code to the ULA.
- modo  out  1  mode to the ULA.
- valido  out  1  high while A/B/operacao/modo form a complete, committed request.
- resultado  out  6  captured ULA result.
- overflow  out  1  captured overflow.
- zero  out  1  captured zero.
- pronto  out  1  high while resultado/overflow/zero hold a valid capture.
- estado  out  3  current FSM state code, for the LEDs.

## Operation
- Synchronizer: botao passes through 2 flops; both flops reset to 1 (released).
- Debouncer tracks a stable level (resets to 1) and a counter (resets to 0).
  - If the synchronized level equals the stable level, clear the counter.
  - Otherwise increment the counter. When it reaches DEBOUNCE_CYCLES-1, take the new stable level and clear the counter.
  - A stable 1->0 transition generates a one-cycle pulse, `press`. Release generates nothing.
  - Holding the button produces exactly one press.
- FSM states, with estado codes:
  - ESPERA_A (0): on press, A <= dado; go to ESPERA_B.
  - ESPERA_B (1): on press, B <= dado; go to ESPERA_OP.
  - ESPERA_OP (2): on press, operacao <= op_sel, modo <= modo_sel, valido <= 1, wait counter <= ULA_LATENCY; go to CALCULA.
  - CALCULA (3): press ignored. Each cycle, if the counter is 1, capture ula_resultado/ula_overflow/ula_zero into resultado/overflow/zero, set pronto <= 1 and go to EXIBE; otherwise decrement the counter.
  - EXIBE (4): on press, valido <= 0 and pronto <= 0; go to ESPERA_A.
  - Codes 5–7 are unreachable; if entered, go to ESPERA_A on the next edge.
- A, B, operacao and modo keep their values until overwritten by their own load step. resultado/overflow/zero keep their values until the next capture.
- Switch inputs are sampled only on the press cycle; changes at any other time have no effect.

## Timing
- Reset (reset_n = 0, asynchronous): all outputs are 0, state = ESPERA_A, wait and debounce counters = 0, synchronizer and stable level = 1.
  - Deassertion takes effect on the next CLOCK_50 edge.
  - Reset during CALCULA aborts the wait with no capture.
- Press latency: after botao falls, it takes 2 synchronizer cycles plus DEBOUNCE_CYCLES cycles until press is high for 1 cycle. The loaded register updates on the edge that samples press.
- A glitch shorter than DEBOUNCE_CYCLES cycles after synchronization produces no press and no state change.
- ULA wait:
  - The edge that loads operacao/modo and raises valido is edge E.
  - The capture occurs on edge E+ULA_LATENCY, and pronto rises on that same edge.
  - valido is high continuously from E until the EXIBE-exit press.
- Only one FSM transition per press. A press coinciding with the CALCULA-to-EXIBE edge is discarded.

## Test plan
Use DEBOUNCE_CYCLES=4 and ULA_LATENCY=3. The ULA stub returns A+B, 3 cycles registered.
- Reset: pulse reset_n low mid-cycle -> all outputs 0 and estado=0 immediately, with no clock edge needed.
- Full sequence: dado=5 press, dado=3 press, op_sel=000 modo_sel=0 press -> A=5, B=3, valido=1, estado=3. Three edges later: resultado=8, overflow=0, zero=0, pronto=1, estado=4.
- Bounce: botao low for 2 cycles, then high -> no press, estado and A unchanged. botao held low for 20 cycles -> exactly one load.
- Ignored/exit presses: press during CALCULA -> no effect, capture still on schedule. Press in EXIBE -> estado=0, valido=0, pronto=0, resultado still 8, A still 5.
- Mid-operation reset: reset_n low at the 2nd CALCULA cycle -> pronto stays 0, resultado=0, estado=0. After release, a fresh sequence works.
- Zero/overflow capture: stub returns 0 with overflow=1 -> resultado=0, zero=1, overflow=1 held through EXIBE while the stub inputs change.
